e_car_motion: RTL and testbench
===============================

E_CAR_MOTION -- requirements
Module: e_car_motion

Interface
REQ-001 SHALL have parameter TRAVEL_CYC, default 8, giving clk cycles spent travelling between adjacent floors (legal range 2..255).
REQ-002 SHALL have parameter DOOR_CYC, default 4, giving clk cycles the door stays open at a serviced floor (legal range 1..255).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 call  input  [3:0]  floor-request buttons, bit n = floor n; level or single-cycle pulse.
REQ-006 dir  input  1  travel direction from the direction block; 1 = up, 0 = down.
REQ-007 curFlr  output  [3:0]  current car floor, one-hot, registered.
REQ-008 pending  output  [3:0]  latched outstanding requests, registered; drives the direction block's button input.
REQ-009 moving  output  1  high while in MOVE.
REQ-010 door_open  output  1  high while in DOOR.
REQ-011 arrive  output  1  one-cycle pulse on each floor step.

Function
REQ-012 SHALL implement FSM states IDLE, MOVE, DOOR; moving and door_open decode directly from state.
REQ-013 pending next value SHALL be (pending | call) & ~clr, where clr is a one-cycle mask equal to curFlr on DOOR entry, else 0.
REQ-014 In DOOR, a call bit matching curFlr SHALL be ignored, so it is not re-latched.
REQ-015 In IDLE, if (pending & curFlr) != 0, SHALL enter DOOR next cycle; this takes priority over MOVE.
REQ-016 In IDLE, if pending != 0 and (pending & curFlr) == 0, SHALL enter MOVE and load the travel counter with TRAVEL_CYC-1.
REQ-017 In IDLE, if pending == 0, SHALL remain in IDLE.
REQ-018 In MOVE, the counter SHALL decrement each cycle; on the cycle it reads 0, SHALL sample dir and step curFlr.
REQ-019 The step SHALL be a one-position shift of curFlr: toward bit 3 if dir=1, toward bit 0 if dir=0.
REQ-020 A step past floor 3 (up) or floor 0 (down) SHALL be suppressed: curFlr holds and arrive is not pulsed.
REQ-021 arrive SHALL pulse in the same cycle curFlr takes its new value.
REQ-022 After a step, SHALL evaluate against the new curFlr: enter DOOR if that floor is pending; else reload the counter and stay in MOVE if pending != 0; else enter IDLE.
REQ-023 On DOOR entry, SHALL clear the pending bit for curFlr and load the door counter with DOOR_CYC-1.
REQ-024 DOOR SHALL last exactly DOOR_CYC cycles, then enter IDLE.
REQ-025 Step-to-step latency in MOVE SHALL be exactly TRAVEL_CYC cycles.
REQ-026 curFlr SHALL remain one-hot at all times after reset.
REQ-027 dir is registered upstream and lags pending by one cycle; it SHALL be sampled only at step time, never on MOVE entry.

Reset
REQ-028 When rst=1 at a clk edge: state=IDLE, curFlr=4'b0001, pending=0, counters=0, arrive=0, moving=0, door_open=0.
REQ-029 rst SHALL override any state, including mid-MOVE and mid-DOOR; rst has priority over call in the same cycle.

Structure
REQ-030 State encoding and floor count (4) SHALL be defined in the shared elevator package, alongside the one-hot floor constants FLR0..FLR3.
REQ-031 SHALL use a single countdown sub-module, e_cycle_timer (load, value, zero flag), instantiated for both travel and door timing.
REQ-032 SHALL be top-level integrable with the direction block: pending feeds its button input, and curFlr feeds its floor input.

Verification
REQ-033 Reset, then call=4'b1000 for 1 cycle with dir tied up -> MOVE; arrive pulses at 8, 16 and 24 cycles after MOVE entry; curFlr ends at 4'b1000; DOOR lasts 4 cycles; pending=0; IDLE.
REQ-034 At floor 0 in IDLE, call=4'b0001 -> DOOR next cycle, no arrive pulse, pending returns to 0.
REQ-035 Car moving up from floor 0 toward 3, call=4'b0100 issued mid-travel -> stops at floor 2 (DOOR, bit 2 cleared), then continues to floor 3.
REQ-036 At floor 3, dir forced to 1 with pending=4'b0001 -> step suppressed, curFlr stays 4'b1000, no arrive pulse.
REQ-037 rst asserted in cycle 5 of MOVE -> next cycle curFlr=4'b0001, pending=0, IDLE, moving=0.
REQ-038 During DOOR at floor 2, call=4'b0100 held -> pending bit 2 stays 0; after DOOR ends, FSM goes to IDLE without reopening.

Source files
------------

// File: rtl/e_car_motion_pkg.sv
// Shared elevator definitions: floor count, one-hot floor constants,
// car state encoding and the floor-step helpers.
package e_car_motion_pkg;

    localparam int NUM_FLR = 4;
    localparam int CNT_W   = 8;

    typedef logic [NUM_FLR-1:0] flr_t;

    localparam flr_t FLR0 = 4'b0001;
    localparam flr_t FLR1 = 4'b0010;
    localparam flr_t FLR2 = 4'b0100;
    localparam flr_t FLR3 = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    // True when a step in the given direction stays inside the shaft.
    function automatic logic can_step(input flr_t flr, input logic up);
        return up ? (flr != FLR3) : (flr != FLR0);
    endfunction

    // One-position shift of the one-hot floor; holds at the end floors.
    function automatic flr_t step_floor(input flr_t flr, input logic up);
        if (!can_step(flr, up))
            return flr;
        return up ? flr_t'(flr << 1) : flr_t'(flr >> 1);
    endfunction

    // Binary floor number of a one-hot floor value.
    function automatic logic [1:0] floor_num(input flr_t flr);
        case (flr)
            FLR1:    return 2'd1;
            FLR2:    return 2'd2;
            FLR3:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/e_cycle_timer.sv
// Loadable down-counter with a zero flag; used for both travel and
// door timing. Counting stops at zero until the next load.
module e_cycle_timer
    import e_car_motion_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count;

    // Load has priority over counting; decrement saturates at zero.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every flop samples the pre-edge values of the others.
        if (rst)
            count <= '0;
        else if (load)
            count <= value;
        else if (en && count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/e_car_motion.sv
// Elevator car motion controller: latches floor requests, moves the car
// one floor per TRAVEL_CYC cycles in the direction supplied by the
// direction block, and holds the door open for DOOR_CYC cycles at each
// requested floor.
module e_car_motion
    import e_car_motion_pkg::*;
#(
    parameter int TRAVEL_CYC = 8,
    parameter int DOOR_CYC   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_FLR-1:0] call,
    input  logic               dir,
    output logic [NUM_FLR-1:0] curFlr,
    output logic [NUM_FLR-1:0] pending,
    output logic               moving,
    output logic               door_open,
    output logic               arrive
);

    localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_CYC - 1);
    localparam logic [CNT_W-1:0] DOOR_LOAD   = CNT_W'(DOOR_CYC - 1);

    state_t       state;
    logic         travel_zero;
    logic         door_zero;
    logic         step_ok;
    logic         at_step;
    logic         door_entry;
    logic         travel_load;
    flr_t         flr_after;
    flr_t         clr;
    flr_t         call_mask;
    flr_t         pending_nxt;

    e_cycle_timer #(.W(CNT_W)) u_travel_tmr (
        .clk   (clk),
        .rst   (rst),
        .load  (travel_load),
        .en    (state == MOVE),
        .value (TRAVEL_LOAD),
        .zero  (travel_zero)
    );

    e_cycle_timer #(.W(CNT_W)) u_door_tmr (
        .clk   (clk),
        .rst   (rst),
        .load  (door_entry),
        .en    (state == DOOR),
        .value (DOOR_LOAD),
        .zero  (door_zero)
    );

    // Next-state decisions: floor after a possible step, DOOR/MOVE entry,
    // and the pending update with the serviced-floor clear mask.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves one unassigned and infers a latch.
        door_entry  = 1'b0;
        travel_load = 1'b0;
        step_ok     = can_step(curFlr, dir);
        at_step     = (state == MOVE) && travel_zero;
        flr_after   = at_step ? step_floor(curFlr, dir) : curFlr;

        case (state)
            IDLE: begin
                door_entry  = |(pending & curFlr);
                travel_load = !door_entry && (|pending);
            end
            MOVE: begin
                if (at_step) begin
                    door_entry  = |(pending & flr_after);
                    travel_load = !door_entry && (|pending);
                end
            end
            default: ;
        endcase

        // The open-door floor cannot be re-requested while it is open.
        call_mask   = (state == DOOR) ? ~curFlr : '1;
        clr         = door_entry ? flr_after : '0;
        pending_nxt = (pending | (call & call_mask)) & ~clr;
    end

    // Car FSM with registered floor, request latch and arrival pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            curFlr  <= FLR0;
            pending <= '0;
            arrive  <= 1'b0;
        end else begin
            pending <= pending_nxt;
            arrive  <= 1'b0;
            case (state)
                IDLE: begin
                    if (door_entry)
                        state <= DOOR;
                    else if (travel_load)
                        state <= MOVE;
                end
                MOVE: begin
                    if (at_step) begin
                        curFlr <= flr_after;
                        arrive <= step_ok;
                        if (door_entry)
                            state <= DOOR;
                        else if (!travel_load)
                            state <= IDLE;
                    end
                end
                DOOR: begin
                    if (door_zero)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign moving    = (state == MOVE);
    assign door_open = (state == DOOR);

endmodule

// File: tb/tb_e_car_motion.sv
// Self-checking bench for e_car_motion: directed scenarios followed by a
// randomized run, every cycle compared against a floor-level model.
module tb_e_car_motion;

    localparam int TRAVEL_CYC = 8;
    localparam int DOOR_CYC   = 4;

    logic       clk;
    logic       rst;
    logic [3:0] call;
    logic       dir;
    logic [3:0] curFlr;
    logic [3:0] pending;
    logic       moving;
    logic       door_open;
    logic       arrive;

    e_car_motion #(.TRAVEL_CYC(TRAVEL_CYC), .DOOR_CYC(DOOR_CYC)) dut (
        .clk       (clk),
        .rst       (rst),
        .call      (call),
        .dir       (dir),
        .curFlr    (curFlr),
        .pending   (pending),
        .moving    (moving),
        .door_open (door_open),
        .arrive    (arrive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: integer floor, request bitmask and cycles remaining
    // until the next event (floor step or door close).
    typedef enum {M_IDLE, M_MOVING, M_DOOR} mode_t;
    mode_t      m_mode = M_IDLE;
    int         m_floor = 0;
    bit   [3:0] m_pend = '0;
    bit         m_arr = 1'b0;
    int         m_travel_left = 0;
    int         m_door_left = 0;

    task automatic model_step();
        bit [3:0] req;
        bit [3:0] clr_m;
        int       tgt;
        if (rst) begin
            m_mode  = M_IDLE;
            m_floor = 0;
            m_pend  = '0;
            m_arr   = 1'b0;
            return;
        end
        req = call;
        if (m_mode == M_DOOR) req[m_floor] = 1'b0;
        clr_m = '0;
        m_arr = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (m_pend[m_floor]) begin
                    m_mode = M_DOOR;
                    m_door_left = DOOR_CYC;
                    clr_m[m_floor] = 1'b1;
                end else if (m_pend != 0) begin
                    m_mode = M_MOVING;
                    m_travel_left = TRAVEL_CYC;
                end
            end
            M_MOVING: begin
                m_travel_left--;
                if (m_travel_left == 0) begin
                    tgt = dir ? m_floor + 1 : m_floor - 1;
                    if (tgt >= 0 && tgt <= 3) begin
                        m_floor = tgt;
                        m_arr = 1'b1;
                    end
                    if (m_pend[m_floor]) begin
                        m_mode = M_DOOR;
                        m_door_left = DOOR_CYC;
                        clr_m[m_floor] = 1'b1;
                    end else if (m_pend != 0) begin
                        m_travel_left = TRAVEL_CYC;
                    end else begin
                        m_mode = M_IDLE;
                    end
                end
            end
            M_DOOR: begin
                m_door_left--;
                if (m_door_left == 0) m_mode = M_IDLE;
            end
            default: ;
        endcase
        m_pend = (m_pend | req) & ~clr_m;
    endtask

    // One clock: advance the model with the applied inputs, then compare
    // all outputs shortly after the edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("cyc", {5'b0, curFlr, pending, moving, door_open, arrive},
              {5'b0, 4'(1 << m_floor), m_pend, m_mode == M_MOVING, m_mode == M_DOOR, m_arr});
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        call = '0;
        cycle();
        rst  = 1'b0;
    endtask

    // Latch a single request and step into MOVE (two edges).
    task automatic start_move(input logic [3:0] req);
        call = req;
        cycle();
        call = '0;
        cycle();
    endtask

    initial begin
        rst  = 1'b1;
        call = '0;
        dir  = 1'b1;

        // Reset state
        do_reset();
        check("rst_state", {5'b0, curFlr, pending, moving, door_open, arrive},
              {5'b0, 4'b0001, 4'b0000, 3'b000});

        // Full trip from floor 0 to floor 3
        dir = 1'b1;
        start_move(4'b1000);
        check("s33_move", 16'(moving), 16'd1);
        for (int n = 1; n <= 24; n++) begin
            cycle();
            if (n % 8 == 0) check("s33_arrive", 16'(arrive), 16'd1);
        end
        check("s33_flr", 16'(curFlr), 16'h8);
        check("s33_door", 16'(door_open), 16'd1);
        check("s33_pend", 16'(pending), 16'd0);
        for (int n = 1; n <= 3; n++) begin
            cycle();
            check("s33_door_hold", 16'(door_open), 16'd1);
        end
        cycle();
        check("s33_idle", {14'b0, moving, door_open}, 16'd0);

        // At floor 3, up-direction step is suppressed
        dir = 1'b1;
        start_move(4'b0001);
        for (int n = 1; n <= TRAVEL_CYC; n++) cycle();
        check("s36_flr", 16'(curFlr), 16'h8);
        check("s36_arrive", 16'(arrive), 16'd0);
        check("s36_moving", 16'(moving), 16'd1);

        // Request at the current floor opens the door without moving
        do_reset();
        call = 4'b0001;
        cycle();
        call = '0;
        cycle();
        check("s34_door", 16'(door_open), 16'd1);
        check("s34_arrive", 16'(arrive), 16'd0);
        check("s34_pend", 16'(pending), 16'd0);

        // Mid-travel request for floor 2 stops the car there first
        do_reset();
        dir = 1'b1;
        start_move(4'b1000);
        for (int n = 1; n <= 29; n++) begin
            call = (n == 4) ? 4'b0100 : 4'b0000;
            cycle();
            if (n == 16) begin
                check("s35_flr2", 16'(curFlr), 16'h4);
                check("s35_door2", 16'(door_open), 16'd1);
                check("s35_pend2", 16'(pending), 16'h8);
            end
        end
        check("s35_flr3", 16'(curFlr), 16'h8);
        check("s35_door3", 16'(door_open), 16'd1);

        // Reset during MOVE
        do_reset();
        start_move(4'b1000);
        for (int n = 1; n <= 4; n++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("s37_state", {5'b0, curFlr, pending, moving, door_open, arrive},
              {5'b0, 4'b0001, 4'b0000, 3'b000});

        // Held call for the open floor is ignored; no reopen afterwards
        do_reset();
        dir = 1'b1;
        start_move(4'b0100);
        for (int n = 1; n <= 22; n++) begin
            call = (n >= 17 && n <= 20) ? 4'b0100 : 4'b0000;
            cycle();
            if (n >= 17 && n <= 20) check("s38_pend", 16'(pending), 16'd0);
            if (n >= 20) check("s38_idle", {14'b0, moving, door_open}, 16'd0);
        end

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(0, 299) == 0);
            call = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
